// File: rtl/regfile_vec_pkg.sv
// Shared types and default sizing for the masked vector register file.
package regfile_vec_pkg;

    localparam int LANES = 3;
    localparam int WIDTH = 18;
    localparam int DEPTH = 16;

    typedef logic [WIDTH-1:0] lane_t;
    typedef lane_t [LANES-1:0] vec_t;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

endpackage

// File: rtl/regfile_vec_clr_fsm.sv
// Bulk-clear sequencer: sweeps every register index once, then pulses done.
module regfile_vec_clr_fsm
    import regfile_vec_pkg::*;
#(
    parameter int NUM_REGS = 16,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output clr_state_t    state,
    output logic [AW-1:0] ptr,
    output logic          clr_busy,
    output logic          clr_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    clr_state_t    r_state;
    logic [AW-1:0] r_ptr;
    logic          r_busy;
    logic          r_done;

    // Requests arriving while busy or done are dropped, never queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == LAST_IDX) begin
                        r_state <= DONE;
                        r_ptr   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ptr   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign state    = r_state;
    assign ptr      = r_ptr;
    assign clr_busy = r_busy;
    assign clr_done = r_done;

endmodule

// File: rtl/regfile_vec_masked.sv
// Vector register file with per-lane write mask, write-to-read bypass and bulk clear.
// Define REGFILE_VEC_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_vec_masked #(
    parameter int  LANES = regfile_vec_pkg::LANES,
    parameter int  WIDTH = regfile_vec_pkg::WIDTH,
    parameter int  DEPTH = regfile_vec_pkg::DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we3,
    input  logic [LANES-1:0]            wmask,
    input  logic [AW-1:0]               ra1,
    input  logic [AW-1:0]               ra2,
    input  logic [AW-1:0]               ra3,
    input  logic [LANES-1:0][WIDTH-1:0] wd3,
    input  logic                        clr_req,
    output logic [LANES-1:0][WIDTH-1:0] rd1,
    output logic [LANES-1:0][WIDTH-1:0] rd2,
    output logic                        clr_busy,
    output logic                        clr_done
);

    import regfile_vec_pkg::*;

    logic [LANES-1:0][WIDTH-1:0] r_mem [DEPTH];

    clr_state_t    w_state;
    logic [AW-1:0] w_ptr;
    logic          w_addrOk;
    logic          w_wrEn;

    regfile_vec_clr_fsm #(.NUM_REGS(DEPTH)) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .state    (w_state),
        .ptr      (w_ptr),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

`ifdef REGFILE_VEC_ZERO_REG_EN
    assign w_addrOk = (ra3 != '0);
`else
    assign w_addrOk = 1'b1;
`endif

    assign w_wrEn = we3 && w_addrOk && (w_state != CLEAR);

    // The clear sweep owns the storage for its whole duration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_state == CLEAR) begin
            r_mem[w_ptr] <= '0;
        end else if (w_wrEn) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask[l]) begin
                    r_mem[ra3][l] <= wd3[l];
                end
            end
        end
    end

    function automatic logic [LANES-1:0][WIDTH-1:0] readPort(input logic [AW-1:0] addr);
        logic [LANES-1:0][WIDTH-1:0] v;
        v = r_mem[addr];
        for (int l = 0; l < LANES; l++) begin
            if (w_wrEn && (addr == ra3) && wmask[l]) begin
                v[l] = wd3[l];
            end
        end
`ifdef REGFILE_VEC_ZERO_REG_EN
        if (addr == '0) begin
            v = '0;
        end
`endif
        return v;
    endfunction

    always_comb begin
        rd1 = readPort(ra1);
        rd2 = readPort(ra2);
    end

endmodule

// File: tb/tb_regfile_vec_masked.sv
// Self-checking bench for regfile_vec_masked against a cycle-level reference model.
// Honours REGFILE_VEC_ZERO_REG_EN when it is defined for the build.
module tb_regfile_vec_masked;

    localparam int LANES = 3;
    localparam int WIDTH = 18;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef REGFILE_VEC_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic                        clk;
    logic                        rst_n;
    logic                        we3;
    logic [LANES-1:0]            wmask;
    logic [AW-1:0]               ra1, ra2, ra3;
    logic [LANES-1:0][WIDTH-1:0] wd3;
    logic                        clr_req;
    logic [LANES-1:0][WIDTH-1:0] rd1, rd2;
    logic                        clr_busy, clr_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents, remaining clear cycles, pending done pulse.
    logic [WIDTH-1:0] mem [DEPTH][LANES];
    int               clrLeft;
    bit               doneFlag;

    regfile_vec_masked dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we3      (we3),
        .wmask    (wmask),
        .ra1      (ra1),
        .ra2      (ra2),
        .ra3      (ra3),
        .wd3      (wd3),
        .clr_req  (clr_req),
        .rd1      (rd1),
        .rd2      (rd2),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic modelReset();
        for (int a = 0; a < DEPTH; a++)
            for (int l = 0; l < LANES; l++)
                mem[a][l] = '0;
        clrLeft  = 0;
        doneFlag = 1'b0;
    endtask

    function automatic logic [LANES*WIDTH-1:0] expRead(input int addr);
        logic [LANES*WIDTH-1:0] v;
        for (int l = 0; l < LANES; l++) begin
            v[l*WIDTH +: WIDTH] = mem[addr][l];
            if (clrLeft == 0 && we3 && addr == int'(ra3) && wmask[l] && !(ZERO_EN && ra3 == 0))
                v[l*WIDTH +: WIDTH] = wd3[l];
        end
        if (ZERO_EN && addr == 0) v = '0;
        return v;
    endfunction

    task automatic modelEdge();
        bit startClr;
        if (clrLeft > 0) begin
            for (int l = 0; l < LANES; l++) mem[DEPTH - clrLeft][l] = '0;
            clrLeft--;
            doneFlag = (clrLeft == 0);
        end else begin
            if (we3 && !(ZERO_EN && ra3 == 0))
                for (int l = 0; l < LANES; l++)
                    if (wmask[l]) mem[ra3][l] = wd3[l];
            startClr = clr_req && !doneFlag;
            if (startClr) clrLeft = DEPTH;
            doneFlag = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [LANES-1:0] m,
                                 input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                 input logic [AW-1:0] a3, input logic [LANES*WIDTH-1:0] d,
                                 input logic clr);
        we3     = we;
        wmask   = m;
        ra1     = a1;
        ra2     = a2;
        ra3     = a3;
        wd3     = d;
        clr_req = clr;
    endtask

    // Compare all outputs with the model at the negedge, then advance one clock.
    task automatic checkOutput(input string tag);
        @(negedge clk);
        check({tag, ".rd1"},  64'(rd1),      64'(expRead(int'(ra1))));
        check({tag, ".rd2"},  64'(rd2),      64'(expRead(int'(ra2))));
        check({tag, ".busy"}, 64'(clr_busy), 64'(clrLeft > 0));
        check({tag, ".done"}, 64'(clr_done), 64'(doneFlag));
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    function automatic logic [LANES*WIDTH-1:0] randVec();
        logic [LANES*WIDTH-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*WIDTH +: WIDTH] = WIDTH'($urandom);
        return v;
    endfunction

    initial begin
        int busyCnt, doneCnt, doneAt;
        logic [LANES*WIDTH-1:0] v;

        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0);
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        $display("[TB] reset readback");
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b0, '0, AW'(a), AW'(DEPTH - 1 - a), '0, '0, 1'b0);
            @(negedge clk);
            check("reset.rd1", 64'(rd1), 64'd0);
            check("reset.rd2", 64'(rd2), 64'd0);
            @(posedge clk); modelEdge(); #1;
        end
        check("reset.busy", 64'(clr_busy), 64'd0);
        check("reset.done", 64'(clr_done), 64'd0);

        $display("[TB] masked write");
        applyStimulus(1'b1, 3'b111, 4'd1, 4'd2, 4'd5, {18'h3FFFF, 18'h00001, 18'h2AAAA}, 1'b0);
        checkOutput("mask.w1");
        applyStimulus(1'b1, 3'b010, 4'd1, 4'd2, 4'd5, '0, 1'b0);
        checkOutput("mask.w2");
        applyStimulus(1'b0, 3'b000, 4'd5, 4'd5, 4'd0, '0, 1'b0);
        #1;
        check("mask.const", 64'(rd1), 64'({18'h3FFFF, 18'h00000, 18'h2AAAA}));
        checkOutput("mask.read");

        $display("[TB] bypass");
        applyStimulus(1'b1, 3'b111, 4'd0, 4'd0, 4'd7, {18'd1, 18'd2, 18'd3}, 1'b0);
        checkOutput("byp.fill");
        applyStimulus(1'b1, 3'b100, 4'd7, 4'd7, 4'd7, {18'd9, 18'd9, 18'd9}, 1'b0);
        #1;
        check("byp.rd1", 64'(rd1), 64'({18'd9, 18'd2, 18'd3}));
        check("byp.rd2", 64'(rd2), 64'({18'd9, 18'd2, 18'd3}));
        checkOutput("byp.same");
        applyStimulus(1'b0, 3'b000, 4'd7, 4'd7, 4'd0, '0, 1'b0);
        #1;
        check("byp.after", 64'(rd1), 64'({18'd9, 18'd2, 18'd3}));

        $display("[TB] bulk clear");
        for (int a = 0; a < DEPTH; a++) begin
            v = randVec() | {18'd1, 18'd1, 18'd1};
            applyStimulus(1'b1, 3'b111, AW'(a), '0, AW'(a), v, 1'b0);
            checkOutput("clr.fill");
        end
        applyStimulus(1'b0, 3'b000, 4'd0, 4'd1, 4'd0, '0, 1'b1);
        busyCnt = 0; doneCnt = 0; doneAt = -1;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) applyStimulus((c == 4), 3'b111, AW'($urandom), AW'($urandom), 4'd3,
                                     randVec(), (c == 6));
            @(negedge clk);
            if (clr_busy) busyCnt++;
            if (clr_done) begin doneCnt++; doneAt = c; end
            check("clr.rd1",  64'(rd1),      64'(expRead(int'(ra1))));
            check("clr.busy", 64'(clr_busy), 64'(clrLeft > 0));
            check("clr.done", 64'(clr_done), 64'(doneFlag));
            @(posedge clk); modelEdge(); #1;
        end
        check("clr.busyCycles", 64'(busyCnt), 64'd16);
        check("clr.donePulses", 64'(doneCnt), 64'd1);
        check("clr.doneCycle",  64'(doneAt),  64'd17);
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b0, '0, AW'(a), AW'(a), '0, '0, 1'b0);
            #1;
            check("clr.zero", 64'(rd1), 64'd0);
        end

        $display("[TB] reset mid-clear");
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b1, 3'b111, '0, '0, AW'(a), randVec() | 54'd1, 1'b0);
            checkOutput("rst.fill");
        end
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1);
        checkOutput("rst.req");
        applyStimulus(1'b0, '0, 4'd12, 4'd15, '0, '0, 1'b0);
        for (int c = 0; c < 8; c++) checkOutput("rst.run");
        rst_n = 1'b0;
        #2;
        modelReset();
        check("rst.rd1",  64'(rd1),      64'd0);
        check("rst.rd2",  64'(rd2),      64'd0);
        check("rst.busy", 64'(clr_busy), 64'd0);
        check("rst.done", 64'(clr_done), 64'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, '0, AW'(c), AW'(c + 3), '0, '0, 1'b0);
            checkOutput("rst.post");
        end

`ifdef REGFILE_VEC_ZERO_REG_EN
        $display("[TB] zero register");
        applyStimulus(1'b1, 3'b111, 4'd0, 4'd0, 4'd0, {18'd5, 18'd5, 18'd5}, 1'b0);
        #1;
        check("zero.same", 64'(rd1), 64'd0);
        checkOutput("zero.write");
        applyStimulus(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, '0, 1'b0);
        #1;
        check("zero.after", 64'(rd1), 64'd0);
`endif

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom), AW'($urandom), AW'($urandom),
                          AW'($urandom_range(0, 3)), randVec(), ($urandom_range(0, 39) == 0));
            if ($urandom_range(0, 3) == 0) ra1 = ra3;
            if ($urandom_range(0, 3) == 0) ra2 = ra3;
            checkOutput("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
